// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// conv3x3_stream : streaming 3x3 convolution over a raster frame, valid region
// Optional macro CONV_SAT_EN: saturate (instead of wrap) the reduced output.
// Rev 1.0
// ============================================================================
module conv3x3_stream #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_st,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              coef_wr,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_din,
    output logic [OUT_W-1:0]  dout,
    output logic              dout_vld,
    output logic              out_st,
    output logic              busy
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 4;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_COL_TWO  = CW'(2);
    localparam logic [RW-1:0] c_ROW_TWO  = RW'(2);
    localparam int c_KDEF [9] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] win_q [9];
    logic [COEF_W-1:0] coef_q [9];
    logic [PROD_W-1:0] prod_q [9];
    logic              win_vld_q, win_last_q;
    logic              prod_vld_q, prod_last_q;
    logic [OUT_W-1:0]  dout_q;
    logic              dout_vld_q, out_st_q;

    logic              w_accept, w_col_end, w_row_end, w_last, w_win, w_corner;
    logic [SUM_W-1:0]  w_sum, w_shift;
    logic [OUT_W-1:0]  w_res;

    assign w_accept  = din_vld && !in_st && (state_q == S_FILL || state_q == S_RUN);
    assign w_col_end = (col_q == c_COL_LAST);
    assign w_row_end = (row_q == c_ROW_LAST);
    assign w_last    = w_col_end && w_row_end;
    assign w_win     = (row_q >= c_ROW_TWO) && (col_q >= c_COL_TWO);
    assign w_corner  = (row_q == c_ROW_TWO) && (col_q == c_COL_TWO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // A frame start overrides whatever the FSM is doing.
    always_comb begin
        state_d = state_q;
        if (in_st) begin
            state_d = S_FILL;
        end else begin
            case (state_q)
                S_FILL:  if (w_accept && w_last)        state_d = S_FLUSH;
                         else if (w_accept && w_corner) state_d = S_RUN;
                S_RUN:   if (w_accept && w_last)        state_d = S_FLUSH;
                S_FLUSH: if (out_st_q)                  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_st) begin
            col_q <= '0;
            row_q <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                col_q <= '0;
                row_q <= w_row_end ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Window index is row*3+col; column 2 is the newest, row 2 the current line.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= din;
            for (int r = 0; r < 3; r++) begin
                win_q[r*3]   <= win_q[r*3+1];
                win_q[r*3+1] <= win_q[r*3+2];
            end
            win_q[2] <= lb1_q[col_q];
            win_q[5] <= lb0_q[col_q];
            win_q[8] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) coef_q[i] <= COEF_W'(c_KDEF[i]);
        end else if (coef_wr && state_q == S_IDLE && coef_addr <= 4'd8) begin
            coef_q[coef_addr] <= coef_din;
        end
    end

    always_ff @(posedge clk) begin
        if (win_vld_q) begin
            for (int i = 0; i < 9; i++) prod_q[i] <= PROD_W'(win_q[i]) * PROD_W'(coef_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_vld_q   <= 1'b0;
            win_last_q  <= 1'b0;
            prod_vld_q  <= 1'b0;
            prod_last_q <= 1'b0;
            dout_vld_q  <= 1'b0;
            out_st_q    <= 1'b0;
            dout_q      <= '0;
        end else begin
            win_vld_q   <= w_accept && w_win;
            win_last_q  <= w_accept && w_last;
            prod_vld_q  <= !in_st && win_vld_q;
            prod_last_q <= !in_st && win_last_q;
            dout_vld_q  <= !in_st && prod_vld_q;
            out_st_q    <= !in_st && prod_last_q;
            if (prod_vld_q) dout_q <= w_res;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) w_sum = w_sum + SUM_W'(prod_q[i]);
    end

    assign w_shift = w_sum >> SHIFT;

    generate
        if (OUT_W > SUM_W) begin : g_wide
            assign w_res = {{(OUT_W-SUM_W){1'b0}}, w_shift};
        end else if (OUT_W == SUM_W) begin : g_equal
            assign w_res = w_shift;
        end else begin : g_narrow
`ifdef CONV_SAT_EN
            assign w_res = (|w_shift[SUM_W-1:OUT_W]) ? {OUT_W{1'b1}} : w_shift[OUT_W-1:0];
`else
            logic w_unused_hi;
            assign w_unused_hi = ^w_shift[SUM_W-1:OUT_W];
            assign w_res       = w_shift[OUT_W-1:0];
`endif
        end
    endgenerate

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign out_st   = out_st_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
// tb_conv3x3_stream : directed and random frames checked against a window-sum model.
module tb_conv3x3_stream;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int SHIFT  = 0;
    localparam int OUT_W  = 16;
    localparam int N_RES  = (IMG_W - 2) * (IMG_H - 2);

    logic              clk = 1'b0;
    logic              rst_n, in_st, din_vld, coef_wr;
    logic [DATA_W-1:0] din;
    logic [3:0]        coef_addr;
    logic [COEF_W-1:0] coef_din;
    logic [OUT_W-1:0]  dout;
    logic              dout_vld, out_st, busy;

    int     cyc = 0;
    int     n_chk = 0;
    int     n_err = 0;
    int     res_cnt, ost_cnt;
    bit     mon_en;
    int     img [IMG_H][IMG_W];
    int     kern [9];
    longint exp_val_q [$];
    int     exp_cyc_q [$];

    conv3x3_stream #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .IMG_W(IMG_W),
        .IMG_H(IMG_H), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in_st(in_st), .din(din), .din_vld(din_vld),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_din(coef_din),
        .dout(dout), .dout_vld(dout_vld), .out_st(out_st), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint reduce(input longint s);
        longint v, maxv;
        v    = s >>> SHIFT;
        maxv = (longint'(1) << OUT_W) - 1;
`ifdef CONV_SAT_EN
        return (v > maxv) ? maxv : v;
`else
        return v & maxv;
`endif
    endfunction

    task automatic set_default_kernel();
        kern = '{8, 16, 8, 16, 32, 16, 8, 16, 8};
    endtask

    task automatic build_img(input int mode);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                case (mode)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = r * IMG_W + c;
                    2:       img[r][c] = 255;
                    default: img[r][c] = int'($urandom_range(0, (1 << DATA_W) - 1));
                endcase
    endtask

    // Valid-region convolution of the whole frame, raster order.
    task automatic build_expect();
        for (int r = 2; r < IMG_H; r++)
            for (int c = 2; c < IMG_W; c++) begin
                longint s = 0;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        s += longint'(img[r-2+kr][c-2+kc]) * longint'(kern[kr*3+kc]);
                exp_val_q.push_back(reduce(s));
            end
    endtask

    task automatic write_coef(input int a, input int v);
        coef_wr   = 1'b1;
        coef_addr = 4'(a);
        coef_din  = COEF_W'(v);
        @(posedge clk); #1;
        coef_wr = 1'b0;
        if (a <= 8) kern[a] = v;
    endtask

    task automatic start_frame();
        in_st = 1'b1;
        @(posedge clk); #1;
        in_st = 1'b0;
    endtask

    // gap: 0 continuous, 1 alternate valid/idle, 2 random idles
    task automatic drive_pix(input int n, input int gap, input int coef_at);
        int idx  = 0;
        int step = 0;
        while (idx < n) begin
            bit v;
            case (gap)
                0:       v = 1'b1;
                1:       v = (step % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            din_vld   = v;
            din       = v ? DATA_W'(img[idx / IMG_W][idx % IMG_W]) : DATA_W'($urandom);
            coef_wr   = (idx == coef_at);
            coef_addr = 4'd4;
            coef_din  = COEF_W'(7);
            if (v && mon_en && (idx / IMG_W) >= 2 && (idx % IMG_W) >= 2)
                exp_cyc_q.push_back(cyc + 3);
            @(posedge clk); #1;
            if (v) idx++;
            step++;
        end
        din_vld = 1'b0;
        coef_wr = 1'b0;
    endtask

    task automatic finish_frame();
        bit seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            if (out_st) seen = 1'b1;
        end
        check_eq("out_st_seen", seen, 1);
        if (seen) begin
            check_eq("busy_at_out_st", busy, 1);
            @(negedge clk);
            check_eq("busy_after_out_st", busy, 0);
        end
        check_eq("result_count", res_cnt, N_RES);
        check_eq("out_st_count", ost_cnt, 1);
        check_eq("pending_expect", exp_val_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic clear_frame_state();
        exp_val_q.delete();
        exp_cyc_q.delete();
        res_cnt = 0;
        ost_cnt = 0;
    endtask

    task automatic run_frame(input int mode, input int gap, input int coef_at);
        build_img(mode);
        clear_frame_state();
        build_expect();
        start_frame();
        drive_pix(IMG_W * IMG_H, gap, coef_at);
        finish_frame();
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (dout_vld) begin
                res_cnt++;
                if (exp_val_q.size() == 0 || exp_cyc_q.size() == 0) begin
                    check_eq("extra_result", 1, 0);
                end else begin
                    check_eq("dout", dout, exp_val_q.pop_front());
                    check_eq("latency", cyc, exp_cyc_q.pop_front());
                end
            end
            if (out_st) begin
                ost_cnt++;
                check_eq("out_st_last", exp_val_q.size(), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_st = 1'b0; din = '0; din_vld = 1'b0;
        coef_wr = 1'b0; coef_addr = '0; coef_din = '0; mon_en = 1'b0;
        set_default_kernel();
        clear_frame_state();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_dout", dout, 0);
        check_eq("reset_dout_vld", dout_vld, 0);
        check_eq("reset_out_st", out_st, 0);
        check_eq("reset_busy", busy, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        run_frame(0, 0, -1);                    // flat 100, default kernel
        run_frame(1, 0, -1);                    // ramp
        run_frame(1, 1, -1);                    // ramp, din_vld toggling

        for (int i = 0; i < 9; i++) write_coef(i, (i == 4) ? 1 : 0);
        write_coef(12, 0);                      // out-of-range address
        run_frame(1, 0, 30);                    // coef write during RUN

        // asynchronous reset at the 20th pixel
        build_img(1);
        mon_en = 1'b0;
        start_frame();
        drive_pix(19, 0, -1);
        din_vld = 1'b1;
        din     = DATA_W'(img[2][3]);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_dout", dout, 0);
        check_eq("midrst_dout_vld", dout_vld, 0);
        check_eq("midrst_out_st", out_st, 0);
        check_eq("midrst_busy", busy, 0);
        din_vld = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        set_default_kernel();
        mon_en = 1'b1;
        run_frame(1, 0, -1);                    // kernel must be back at default

        // abort at the 40th pixel, restart carries a dropped pixel
        build_img(1);
        mon_en = 1'b0;
        start_frame();
        drive_pix(39, 0, -1);
        in_st   = 1'b1;
        din_vld = 1'b1;
        din     = DATA_W'(img[4][7]);
        @(posedge clk); #1;
        in_st   = 1'b0;
        din_vld = 1'b0;
        clear_frame_state();
        mon_en = 1'b1;
        build_expect();
        drive_pix(IMG_W * IMG_H, 0, -1);
        finish_frame();

        for (int i = 0; i < 9; i++) write_coef(i, 255);
        run_frame(2, 0, -1);                    // maximum sum

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 9; i++) write_coef(i, int'($urandom_range(0, 255)));
            run_frame(3, 2, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised streaming 3×3 2D convolution engine for single-channel unsigned images.
- Accepts one frame in raster order and buffers two image lines internally, so no full-frame store is needed.
- Emits the valid-region ("no padding") result map of (IMG_W-2)×(IMG_H-2) pixels.
- Kernel coefficients are runtime-writable.
- Sits between the image RAM reader and the result consumer.

## Interface
Parameters:
- DATA_W, 8, input pixel width (unsigned)
- COEF_W, 8, coefficient width (unsigned Q1.(COEF_W-1))
- IMG_W, 8, image width in pixels (≥3)
- IMG_H, 8, image height in lines (≥3)
- SHIFT, 0, right shift applied to the full-precision sum before output
- OUT_W, 16, output width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_st  in  1  frame start pulse; clears counters and pipeline, enters FILL
- din  in  DATA_W  input pixel
- din_vld  in  1  din valid; accepted when state is FILL or RUN
- coef_wr  in  1  coefficient write strobe (honoured only in IDLE)
- coef_addr  in  4  coefficient index 0..8, raster order of the kernel
- coef_din  in  COEF_W  coefficient value
- dout  out  OUT_W  convolution result
- dout_vld  out  1  dout valid, one cycle per result
- out_st  out  1  one-cycle pulse coincident with the last dout_vld of a frame
- busy  out  1  high in FILL, RUN, FLUSH

## Operation
- States: IDLE → (in_st) FILL → RUN → FLUSH → IDLE.
  - FILL: the first 2×IMG_W+2 pixels are accepted; no window is complete yet.
  - RUN: transition occurs on acceptance of the pixel at (row 2, col 2).
  - FLUSH: entered on acceptance of pixel (IMG_H-1, IMG_W-1); returns to IDLE once the 2-stage pipeline drains.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance per accepted pixel. col wraps to 0 and increments row.
- Line buffers:
  - lb0 holds the previous line; lb1 holds the line before it. Each has depth IMG_W.
  - On each accept: lb1[col]←lb0[col] and lb0[col]←din.
  - Window shift registers shift in the column {lb1[col], lb0[col], din}.
- A window is valid when row≥2 and col≥2. Its result maps to output position (row-2, col-2).
- Windows straddling a line wrap (col<2) are discarded.
- Arithmetic:
  - Nine DATA_W×COEF_W unsigned products.
  - Adder tree into DATA_W+COEF_W+4 bits, no loss.
  - Result = sum >> SHIFT, then reduced to OUT_W (see Configuration).
- Kernel reset value: {8,16,8,16,32,16,8,16,8}, i.e. Gaussian 1/16,1/8,1/4 in Q1.7. Values are zero-extended if COEF_W>8.
- din_vld is ignored in IDLE and FLUSH. coef_wr is ignored outside IDLE. coef_addr>8 is ignored.
- in_st in any state aborts the current frame:
  - clears row, col and the pipeline valid bits; coefficients are kept;
  - enters FILL;
  - suppresses out_st for the aborted frame.
- in_st and din_vld asserted in the same cycle: in_st wins and the pixel is dropped.

## Timing
- Reset values:
  - dout=0, dout_vld=0, out_st=0, busy=0;
  - state IDLE, counters 0, kernel at default.
  - Line buffer contents are don't-care.
- Latency: pixel accepted at edge k completes a window → products registered at k+1 → dout and dout_vld registered at k+2.
- Throughput: one result per accepted pixel in valid windows.
- Gaps in din_vld stall the pipeline input only; in-flight results still emerge.
- out_st is high in the same cycle as the (IMG_W-2)×(IMG_H-2)-th dout_vld. busy falls on the following edge.
- A coefficient write at edge k is used by any window whose products register after k.

## Configuration
- CONV_SAT_EN defined: the shifted sum saturates to 2^OUT_W-1 when it exceeds the OUT_W range.
- CONV_SAT_EN undefined: the shifted sum is truncated to its low OUT_W bits (wraps).

## Test plan
- 8×8 frame, all pixels 100, default kernel, din_vld continuous → exactly 36 dout_vld, each dout=12800; out_st on the 36th; busy low 1 cycle later.
- 8×8 ramp, pixel=row×8+col, default kernel → first dout=1152 (centre 9×128), last dout=6912; raster-ordered outputs = 128×centre value.
- Same ramp with din_vld toggling 1/0 each cycle → identical 36 values; each dout_vld exactly 2 cycles after its completing accept.
- In IDLE, write coef 4=1 and all others 0; ramp frame → dout equals the centre pixel (first 9, last 54). A coef_wr issued during RUN is ignored.
- All pixels 255, all coefficients 255 → sum 585225: dout=65535 with CONV_SAT_EN, 60937 without.
- Reset scenarios:
  - rst_n low at the 20th pixel → all outputs 0 immediately and kernel back to default.
  - in_st at the 40th pixel, then a full frame → exactly 36 results and one out_st.
